// File: rtl/genius_score_fsm_pkg.sv
// -----------------------------------------------------------------------------
// genius_pkg
// Shared constants for the Genius (Simon) score controller: display-code
// width and glyph codes, the highest playable level and the FSM state
// encodings. Imported by the controller top and by the testbench.
// -----------------------------------------------------------------------------
package genius_pkg;

  // Width of the code handed to the two-digit seven-segment decoder
  localparam int CODE_W    = 6;

  // Decoder glyph codes; 0..32 are shown as a decimal score
  localparam int CODE_FAIL = 33;
  localparam int CODE_WIN  = 34;

  // Highest level the game supports
  localparam int MAX_SCORE = 32;

  // Controller states (plain constants so legacy tools can read them)
  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE      = 3'd0;
  localparam state_t ST_PLAY      = 3'd1;
  localparam state_t ST_FAIL_SHOW = 3'd2;
  localparam state_t ST_FAIL_DONE = 3'd3;
  localparam state_t ST_WIN_SHOW  = 3'd4;

endpackage

// File: rtl/genius_score_fsm_if.sv
// -----------------------------------------------------------------------------
// genius_score_fsm_if
// Bundles the sequencer-side requests and the display/status outputs of the
// score controller.
//   start      : start/restart request (level; controller acts on rising edge)
//   round_ok   : round completed correctly (rising edge)
//   round_err  : player error (rising edge)
//   disp_code  : 6-bit code for the seven-segment decoder
//   level      : current level / final score
//   busy       : game in progress
//   game_over  : failure glyph or final score being shown
//   win        : victory glyph being shown
// master drives the requests, slave (the controller) drives the status.
// -----------------------------------------------------------------------------
interface genius_score_fsm_if;
  import genius_pkg::*;

  logic              start;
  logic              round_ok;
  logic              round_err;
  logic [CODE_W-1:0] disp_code;
  logic [CODE_W-1:0] level;
  logic              busy;
  logic              game_over;
  logic              win;

  modport master (
    output start, round_ok, round_err,
    input  disp_code, level, busy, game_over, win
  );

  modport slave (
    input  start, round_ok, round_err,
    output disp_code, level, busy, game_over, win
  );

endinterface

// File: rtl/genius_score_fsm_rise_detect.sv
// -----------------------------------------------------------------------------
// rise_detect
// Single-register rising-edge detector.
//   clk   : system clock
//   rst_n : asynchronous active-low reset (clears the history register)
//   din   : level input
//   rise  : high while din is high and was low at the previous clock edge
// Because the history clears to 0, an input already high when reset is
// released produces a rise on the first clock.
// -----------------------------------------------------------------------------
module rise_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic rise
);

  logic din_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) din_prev <= 1'b0;
    else        din_prev <= din;
  end

  assign rise = din & ~din_prev;

endmodule

// File: rtl/genius_score_fsm.sv
// -----------------------------------------------------------------------------
// genius_score_fsm
// Game-progress controller for the Genius (Simon) game. Tracks the player's
// level and produces the display code for the two-digit seven-segment decoder
// (0..32 score, CODE_FAIL failure glyph, CODE_WIN victory glyph).
//   clk   : system clock, all state updates on rising edge
//   rst_n : asynchronous active-low reset
//   bus   : slave side of genius_score_fsm_if (requests in, status out)
// All outputs are registered and computed from the next state, so an event
// is visible right after the clock edge at which its rise is sampled.
// -----------------------------------------------------------------------------
module genius_score_fsm #(
  parameter int MAX_LEVEL   = genius_pkg::MAX_SCORE,
  parameter int HOLD_CYCLES = 50000000,
  parameter int CODE_FAIL   = genius_pkg::CODE_FAIL,
  parameter int CODE_WIN    = genius_pkg::CODE_WIN
) (
  input  logic               clk,
  input  logic               rst_n,
  genius_score_fsm_if.slave  bus
);
  import genius_pkg::*;

  localparam int TMR_W = $clog2(HOLD_CYCLES);
  localparam logic [TMR_W-1:0]  TMR_LAST = TMR_W'(HOLD_CYCLES - 1);
  localparam logic [CODE_W-1:0] LVL_MAX  = CODE_W'(MAX_LEVEL);

  logic rise_start, rise_ok, rise_err;

  rise_detect u_rd_start (.clk(clk), .rst_n(rst_n), .din(bus.start),     .rise(rise_start));
  rise_detect u_rd_ok    (.clk(clk), .rst_n(rst_n), .din(bus.round_ok),  .rise(rise_ok));
  rise_detect u_rd_err   (.clk(clk), .rst_n(rst_n), .din(bus.round_err), .rise(rise_err));

  state_t            state_q, state_d;
  logic [CODE_W-1:0] level_q, level_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic [CODE_W-1:0] disp_code_q;
  logic              busy_q, game_over_q, win_q;

  // Display code for a given state/level pair; unused states show 0 so the
  // decoder never sees an undefined code.
  function automatic logic [CODE_W-1:0] code_for(input state_t st,
                                                 input logic [CODE_W-1:0] lvl);
    case (st)
      ST_PLAY,
      ST_FAIL_DONE: code_for = lvl;
      ST_FAIL_SHOW: code_for = CODE_W'(CODE_FAIL);
      ST_WIN_SHOW:  code_for = CODE_W'(CODE_WIN);
      default:      code_for = '0;
    endcase
  endfunction

  always_comb begin
    state_d = state_q;
    level_d = level_q;
    timer_d = timer_q;
    case (state_q)
      ST_IDLE: begin
        if (rise_start) begin
          state_d = ST_PLAY;
          level_d = '0;
          timer_d = '0;
        end
      end
      ST_PLAY: begin
        // start is ignored while playing; error beats a simultaneous ok
        if (rise_err) begin
          state_d = ST_FAIL_SHOW;
          timer_d = '0;
        end else if (rise_ok) begin
          if (level_q + 6'd1 == LVL_MAX) begin
            state_d = ST_WIN_SHOW;
            level_d = LVL_MAX;
          end else begin
            level_d = level_q + 6'd1;
          end
        end
      end
      ST_FAIL_SHOW: begin
        if (rise_start) begin
          state_d = ST_PLAY;
          level_d = '0;
          timer_d = '0;
        end else if (timer_q == TMR_LAST) begin
          // glyph has now been shown for HOLD_CYCLES cycles
          state_d = ST_FAIL_DONE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      ST_FAIL_DONE,
      ST_WIN_SHOW: begin
        if (rise_start) begin
          state_d = ST_PLAY;
          level_d = '0;
          timer_d = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        level_d = '0;
        timer_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      level_q     <= '0;
      timer_q     <= '0;
      disp_code_q <= '0;
      busy_q      <= 1'b0;
      game_over_q <= 1'b0;
      win_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      level_q     <= level_d;
      timer_q     <= timer_d;
      disp_code_q <= code_for(state_d, level_d);
      busy_q      <= (state_d == ST_PLAY);
      game_over_q <= (state_d == ST_FAIL_SHOW) || (state_d == ST_FAIL_DONE);
      win_q       <= (state_d == ST_WIN_SHOW);
    end
  end

  assign bus.disp_code = disp_code_q;
  assign bus.level     = level_q;
  assign bus.busy      = busy_q;
  assign bus.game_over = game_over_q;
  assign bus.win       = win_q;

endmodule

// File: tb/tb_genius_score_fsm.sv
// -----------------------------------------------------------------------------
// tb_genius_score_fsm
// Directed bench for genius_score_fsm with MAX_LEVEL=3, HOLD_CYCLES=4.
// Each step drives the inputs, queues the expected outputs, and compares
// them one clock edge later.
// -----------------------------------------------------------------------------
module tb_genius_score_fsm;
  import genius_pkg::*;

  typedef struct packed {
    logic [5:0] code;
    logic [5:0] lvl;
    logic       busy;
    logic       go;
    logic       win;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  genius_score_fsm_if bus ();

  genius_score_fsm #(
    .MAX_LEVEL   (3),
    .HOLD_CYCLES (4),
    .CODE_FAIL   (33),
    .CODE_WIN    (34)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  exp_t sbq[$];
  int   tests_run = 0;
  int   fails     = 0;

  function automatic exp_t mk(input int code, input int lvl, input logic b,
                              input logic g, input logic w);
    exp_t e;
    e.code = 6'(code);
    e.lvl  = 6'(lvl);
    e.busy = b;
    e.go   = g;
    e.win  = w;
    return e;
  endfunction

  function automatic exp_t idle();          return mk(0, 0, 1'b0, 1'b0, 1'b0);  endfunction
  function automatic exp_t play(input int l); return mk(l, l, 1'b1, 1'b0, 1'b0);  endfunction
  function automatic exp_t fshow(input int l); return mk(33, l, 1'b0, 1'b1, 1'b0); endfunction
  function automatic exp_t fdone(input int l); return mk(l, l, 1'b0, 1'b1, 1'b0);  endfunction
  function automatic exp_t won();            return mk(34, 3, 1'b0, 1'b0, 1'b1);  endfunction

  task automatic check(input string tag, input exp_t e);
    tests_run++;
    assert (bus.disp_code === e.code) else begin
      fails++;
      $error("FAIL %s disp_code got %0d expected %0d", tag, bus.disp_code, e.code);
    end
    tests_run++;
    assert (bus.level === e.lvl) else begin
      fails++;
      $error("FAIL %s level got %0d expected %0d", tag, bus.level, e.lvl);
    end
    tests_run++;
    assert (bus.busy === e.busy) else begin
      fails++;
      $error("FAIL %s busy got %b expected %b", tag, bus.busy, e.busy);
    end
    tests_run++;
    assert (bus.game_over === e.go) else begin
      fails++;
      $error("FAIL %s game_over got %b expected %b", tag, bus.game_over, e.go);
    end
    tests_run++;
    assert (bus.win === e.win) else begin
      fails++;
      $error("FAIL %s win got %b expected %b", tag, bus.win, e.win);
    end
  endtask

  // Drive inputs now, expect e right after the next rising edge
  task automatic cyc(input string tag, input logic s, input logic ok,
                     input logic err, input exp_t e);
    bus.start     = s;
    bus.round_ok  = ok;
    bus.round_err = err;
    sbq.push_back(e);
    @(posedge clk);
    #1;
    check(tag, sbq.pop_front());
  endtask

  // Assert reset away from any clock edge and check outputs clear at once
  task automatic async_reset(input string tag);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check(tag, idle());
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start     = 1'b0;
    bus.round_ok  = 1'b0;
    bus.round_err = 1'b0;
    rst_n         = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("por", idle());
    @(negedge clk);
    rst_n = 1'b1;

    // Start and level counting to a win
    cyc("idle",        0, 0, 0, idle());
    cyc("start",       1, 0, 0, play(0));
    cyc("play0",       0, 0, 0, play(0));
    cyc("ok1",         0, 1, 0, play(1));
    cyc("hold1",       0, 0, 0, play(1));
    cyc("ok2",         0, 1, 0, play(2));
    for (int i = 0; i < 4; i++) cyc("ok_held", 0, 1, 0, play(2));
    cyc("ok_rel",      0, 0, 0, play(2));
    cyc("ok_win",      0, 1, 0, won());
    cyc("win_hold",    0, 0, 0, won());
    cyc("win_ok_ign",  0, 1, 0, won());
    cyc("win_gap",     0, 0, 0, won());
    cyc("win_err_ign", 0, 0, 1, won());
    cyc("win_gap2",    0, 0, 0, won());

    // Restart, reach level 2, fail and hold
    cyc("restart",     1, 0, 0, play(0));
    cyc("rs_gap",      0, 0, 0, play(0));
    cyc("l1",          0, 1, 0, play(1));
    cyc("l1_gap",      0, 0, 0, play(1));
    cyc("l2",          0, 1, 0, play(2));
    cyc("l2_gap",      0, 0, 0, play(2));
    cyc("err_c1",      0, 0, 1, fshow(2));
    cyc("err_c2",      0, 0, 0, fshow(2));
    cyc("err_c3",      0, 0, 0, fshow(2));
    cyc("err_c4",      0, 0, 0, fshow(2));
    cyc("fdone",       0, 0, 0, fdone(2));
    cyc("fdone_ok_ign",0, 1, 0, fdone(2));
    cyc("fdone_gap",   0, 0, 0, fdone(2));
    cyc("fd_start",    1, 0, 0, play(0));
    cyc("fd_gap",      0, 0, 0, play(0));

    // Simultaneous ok+err at level 1, then abort the hold with start
    cyc("s_l1",        0, 1, 0, play(1));
    cyc("s_gap",       0, 0, 0, play(1));
    cyc("okerr",       0, 1, 1, fshow(1));
    cyc("okerr_c2",    0, 0, 0, fshow(1));
    cyc("abort",       1, 0, 0, play(0));
    cyc("abort_gap",   0, 0, 0, play(0));
    cyc("start_ok",    1, 1, 0, play(1));
    cyc("so_gap",      0, 0, 0, play(1));
    cyc("e2_c1",       0, 0, 1, fshow(1));
    cyc("e2_c2",       0, 0, 0, fshow(1));
    cyc("e2_c3",       0, 0, 0, fshow(1));
    cyc("e2_c4",       0, 0, 0, fshow(1));
    cyc("e2_done",     0, 0, 0, fdone(1));

    // Reset in the middle of the hold
    cyc("r_start",     1, 0, 0, play(0));
    cyc("r_gap",       0, 0, 0, play(0));
    cyc("r_err",       0, 0, 1, fshow(0));
    cyc("r_hold",      0, 0, 0, fshow(0));
    async_reset("midhold_rst");
    cyc("r_idle",      0, 0, 0, idle());
    cyc("idle_ok_ign", 0, 1, 0, idle());
    cyc("idle_gap",    0, 0, 0, idle());
    cyc("n_start",     1, 0, 0, play(0));
    cyc("n_gap",       0, 0, 0, play(0));
    cyc("n_ok",        0, 1, 0, play(1));
    cyc("n_ok_gap",    0, 0, 0, play(1));
    cyc("n_err_c1",    0, 0, 1, fshow(1));
    cyc("n_err_c2",    0, 0, 0, fshow(1));
    cyc("n_err_c3",    0, 0, 0, fshow(1));
    cyc("n_err_c4",    0, 0, 0, fshow(1));
    cyc("n_done",      0, 0, 0, fdone(1));

    // start already high when reset is released counts on the first clock
    @(posedge clk);
    #3;
    rst_n     = 1'b0;
    bus.start = 1'b1;
    #1;
    check("rst_with_start", idle());
    @(negedge clk);
    rst_n = 1'b1;
    cyc("start_at_release", 1, 0, 0, play(0));
    cyc("sar_held",         1, 0, 0, play(0));

    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
